// File: rtl/uart_tx_ctrl.sv
`timescale 1ns/1ps
// UART transmit controller: frames a byte and sequences an external PISO serializer.
// Optional even parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_ctrl #(
    parameter int CLK_DIV = 16,
    parameter int DW      = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tx_start,
    input  logic [7:0]    tx_data,
    output logic          tx_busy,
    output logic          tx_done,
    output logic          piso_enb,
    output logic          piso_load,
    output logic          piso_shift,
    output logic          piso_fsm_reset,
    output logic [DW-1:0] piso_frame
);

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int             BW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0]  BAUD_MAX = BW'(CLK_DIV - 1);
    localparam logic [3:0]     BIT_LAST = 4'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t           r_state, w_next;
    logic [BW-1:0]    r_baud;
    logic [3:0]       r_bit;
    logic [DW-1:0]    r_frame;
    logic [DW-1:0]    w_frame;
    logic [7:0]       w_rev;
    logic [NBITS-1:0] w_bits;
    logic             w_baud_end;

    assign w_baud_end = (r_baud == BAUD_MAX);
    assign piso_frame = r_frame;

    // Data goes out LSB first, so it sits bit-reversed in the MSB-first frame.
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < 8; i++) w_rev[7-i] = tx_data[i];
`ifdef UART_TX_PARITY_EN
        w_bits = {1'b0, w_rev, ^tx_data, 1'b1};
`else
        w_bits = {1'b0, w_rev, 1'b1};
`endif
        w_frame = '1;
        for (int i = 0; i < NBITS; i++) w_frame[DW-1-i] = w_bits[NBITS-1-i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Frame is captured only in IDLE, so requests during a frame cannot disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_frame <= '1;
        end else begin
            case (r_state)
                IDLE: if (tx_start) r_frame <= w_frame;
                LOAD: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                end
                SEND: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit != BIT_LAST) r_bit <= r_bit + 4'd1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next         = r_state;
        tx_busy        = 1'b0;
        tx_done        = 1'b0;
        piso_enb       = 1'b0;
        piso_load      = 1'b0;
        piso_shift     = 1'b0;
        piso_fsm_reset = 1'b0;
        case (r_state)
            IDLE: begin
                piso_fsm_reset = 1'b1;
                if (tx_start) w_next = LOAD;
            end
            LOAD: begin
                piso_enb  = 1'b1;
                piso_load = 1'b1;
                tx_busy   = 1'b1;
                w_next    = SEND;
            end
            SEND: begin
                tx_busy = 1'b1;
                if (w_baud_end) begin
                    if (r_bit != BIT_LAST) begin
                        piso_enb   = 1'b1;
                        piso_shift = 1'b1;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                tx_done        = 1'b1;
                tx_busy        = 1'b1;
                piso_fsm_reset = 1'b1;
                w_next         = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_ctrl with a behavioural PISO model to observe the serial line.
module tb_uart_tx_ctrl;
    localparam int CLK_DIV = 4;
    localparam int DW      = 11;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [DW-1:0] EXP_A5 = 11'b01010010101;
    localparam logic [DW-1:0] EXP_FF = 11'b01111111101;
    localparam logic [DW-1:0] EXP_81 = 11'b01000000101;
    localparam logic [DW-1:0] EXP_3C = 11'b00011110001;
`else
    localparam int NB = 10;
    localparam logic [DW-1:0] EXP_A5 = 11'b01010010111;
    localparam logic [DW-1:0] EXP_FF = 11'b01111111111;
    localparam logic [DW-1:0] EXP_81 = 11'b01000000111;
    localparam logic [DW-1:0] EXP_3C = 11'b00011110011;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tx_start = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_busy, tx_done, piso_enb, piso_load, piso_shift, piso_fsm_reset;
    logic [DW-1:0] piso_frame;

    uart_tx_ctrl #(.CLK_DIV(CLK_DIV), .DW(DW)) dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .piso_enb(piso_enb),
        .piso_load(piso_load), .piso_shift(piso_shift),
        .piso_fsm_reset(piso_fsm_reset), .piso_frame(piso_frame)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, n_shift = 0, n_done = 0, n_load = 0;
    bit in_frame = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // External serializer model: line is the MSB of the shift register.
    logic [DW-1:0] sreg;
    logic          line;
    assign line = sreg[DW-1];
    always @(posedge clk) begin
        if (piso_fsm_reset)              sreg <= '1;
        else if (piso_enb && piso_load)  sreg <= piso_frame;
        else if (piso_enb && piso_shift) sreg <= {sreg[DW-2:0], 1'b1};
    end

    // Per-cycle protocol checks and event counters.
    always @(negedge clk) begin
        if (reset) in_frame = 1'b0;
        chk("load_shift_overlap", 32'(piso_load & piso_shift), 32'd0);
        chk("busy_window", 32'(tx_busy), 32'(piso_load | in_frame));
        if (piso_shift) n_shift++;
        if (tx_done)    n_done++;
        if (piso_load)  n_load++;
        if (piso_load)  in_frame = 1'b1;
        if (tx_done)    in_frame = 1'b0;
    end

    // Caller has raised tx_start at a negedge while idle.
    task automatic frame(input logic [DW-1:0] exp, input bit hold, input int glitch_bit,
                         input int rst_bit, output bit aborted);
        int s0, d0;
        s0 = n_shift;
        d0 = n_done;
        aborted = 1'b0;
        @(negedge clk);
        if (!hold) tx_start = 1'b0;
        chk("load_cycle", 32'({piso_load, piso_enb, tx_busy, piso_fsm_reset}), 32'b1110);
        chk("frame_word", 32'(piso_frame), 32'(exp));
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                @(negedge clk);
                chk($sformatf("line_bit%0d", b), 32'(line), 32'(exp[DW-1-b]));
                chk("send_ctl", 32'({tx_busy, piso_fsm_reset, tx_done}), 32'b100);
                if (b == glitch_bit && c == 0) begin
                    tx_start = 1'b1;
                    tx_data  = 8'h00;
                end else if (b == glitch_bit && c == 1) begin
                    tx_start = 1'b0;
                end
                if (b == rst_bit && c == 1) begin
                    #2 reset = 1'b1;
                    #1;
                    chk("reset_abort_ctl", 32'({tx_busy, tx_done, piso_enb, piso_load,
                        piso_shift, piso_fsm_reset}), 32'b000001);
                    chk("reset_abort_frame", 32'(piso_frame), 32'({DW{1'b1}}));
                    aborted = 1'b1;
                    return;
                end
            end
        end
        @(negedge clk);
        chk("done_cycle", 32'({tx_done, tx_busy, piso_fsm_reset, piso_enb}), 32'b1110);
        @(negedge clk);
        chk("idle_after_done", 32'({tx_busy, tx_done, piso_fsm_reset}), 32'b001);
        chk("shift_count", 32'(n_shift - s0), 32'(NB - 1));
        chk("done_count", 32'(n_done - d0), 32'd1);
        chk("line_idle_high", 32'(line), 32'd1);
    endtask

    initial begin
        bit ab;
        int l0, d0;
        #12;
        chk("reset_ctl", 32'({tx_busy, tx_done, piso_enb, piso_load, piso_shift, piso_fsm_reset}),
            32'b000001);
        chk("reset_frame", 32'(piso_frame), 32'({DW{1'b1}}));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ctl", 32'({tx_busy, tx_done, piso_enb, piso_load, piso_shift, piso_fsm_reset}),
            32'b000001);

        tx_data = 8'hA5; tx_start = 1'b1;
        frame(EXP_A5, 1'b0, -1, -1, ab);

        tx_data = 8'hFF; tx_start = 1'b1;
        frame(EXP_FF, 1'b0, -1, -1, ab);

        // Request during bit 3 must neither alter nor queue.
        tx_data = 8'hA5; tx_start = 1'b1;
        frame(EXP_A5, 1'b0, 3, -1, ab);
        l0 = n_load;
        repeat (6) @(negedge clk);
        chk("no_queued_frame", 32'(n_load - l0), 32'd0);
        chk("idle_after_glitch", 32'(tx_busy), 32'd0);

        // Held start: back-to-back frames with one idle cycle between.
        tx_data = 8'h3C; tx_start = 1'b1;
        frame(EXP_3C, 1'b1, -1, -1, ab);
        frame(EXP_3C, 1'b0, -1, -1, ab);
        l0 = n_load;
        repeat (4) @(negedge clk);
        chk("held_release_no_load", 32'(n_load - l0), 32'd0);

        // Reset in the middle of bit 5.
        d0 = n_done;
        tx_data = 8'hFF; tx_start = 1'b1;
        frame(EXP_FF, 1'b0, -1, 5, ab);
        chk("reset_aborted", 32'(ab), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        chk("abort_line_high", 32'(line), 32'd1);
        chk("abort_idle_busy", 32'(tx_busy), 32'd0);

        tx_data = 8'h81; tx_start = 1'b1;
        frame(EXP_81, 1'b0, -1, -1, ab);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter DW, default 11, meaning width of the frame word driven to the serializer.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tx_start  input  1  request to send tx_data; sampled only in IDLE.
REQ-006 SHALL have port tx_data  input  8  payload byte.
REQ-007 SHALL have port tx_busy  output  1  high while a frame is in progress.
REQ-008 SHALL have port tx_done  output  1  one-cycle pulse at frame end.
REQ-009 SHALL have ports piso_enb, piso_load, piso_shift, piso_fsm_reset  output  1 each  serializer controls (enable, parallel load, shift one bit, force line high).
REQ-010 SHALL have port piso_frame  output  DW  frame word for parallel load; bit DW-1 leaves the serializer first.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, SEND, DONE.
REQ-012 IDLE: piso_fsm_reset=1, tx_busy=0, all other controls 0; tx_start=1 at a rising edge captures tx_data and moves to LOAD.
REQ-013 LOAD (exactly 1 cycle): piso_enb=1, piso_load=1, tx_busy=1; bit_cnt and baud_cnt cleared; then SEND.
REQ-014 SEND: piso_fsm_reset=0, tx_busy=1; baud_cnt counts 0..CLK_DIV-1 and wraps to 0.
REQ-015 SEND, baud_cnt=CLK_DIV-1 and bit_cnt<NBITS-1: piso_enb=1 and piso_shift=1 for that single cycle, bit_cnt increments.
REQ-016 SEND, baud_cnt=CLK_DIV-1 and bit_cnt=NBITS-1: no shift; next state DONE.
REQ-017 DONE (exactly 1 cycle): tx_done=1, tx_busy=1, piso_fsm_reset=1; then IDLE.
REQ-018 piso_load and piso_shift SHALL never be high in the same cycle.
REQ-019 Frame word, MSB-first: start bit 0, then tx_data[0]..tx_data[7], then parity (only when configured), then stop bit 1; all unused low bits SHALL be 1.
REQ-020 Each frame bit SHALL be presented on the serial line for exactly CLK_DIV cycles; total SEND time is NBITS*CLK_DIV cycles.
REQ-021 tx_start while tx_busy=1 SHALL be ignored (neither queued nor able to corrupt the captured byte); tx_start held high SHALL re-trigger on the cycle after DONE.
REQ-022 Latency: tx_start sampled at edge k causes LOAD during cycle k..k+1; the start bit is on the line from edge k+1 for CLK_DIV cycles.
REQ-023 baud_cnt SHALL be ceil(log2(CLK_DIV)) bits wide; bit_cnt SHALL be 4 bits wide.

Reset
REQ-024 reset=1 SHALL force IDLE immediately, independent of clk.
REQ-025 While reset=1 the outputs SHALL be: tx_busy=0, tx_done=0, piso_enb=0, piso_load=0, piso_shift=0, piso_fsm_reset=1, piso_frame=all ones.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no tx_done; the line SHALL return high via piso_fsm_reset.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: NBITS=11; even-parity bit (XOR of tx_data) is placed after tx_data[7].
REQ-028 Macro UART_TX_PARITY_EN undefined: NBITS=10; no parity bit is sent; stop bit directly follows tx_data[7].

Verification
REQ-029 CLK_DIV=4, parity on, tx_data=0xA5 -> line sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles; tx_done pulses once, 44 cycles after LOAD.
REQ-030 CLK_DIV=4, parity off, tx_data=0xFF -> line sequence 0,1,1,1,1,1,1,1,1,1; SEND lasts 40 cycles; exactly 9 piso_shift pulses.
REQ-031 tx_start pulsed at SEND bit 3 with tx_data=0x00 -> current frame is unaltered; no second frame follows.
REQ-032 tx_start held high, data 0x3C -> back-to-back frames with exactly one IDLE cycle between DONE and the next LOAD.
REQ-033 reset asserted at SEND bit 5 -> same-cycle IDLE, piso_fsm_reset=1, tx_busy=0, no tx_done; after release, a new frame 0x81 sends correctly.
REQ-034 Every cycle checks: piso_load and piso_shift never both high; tx_busy=1 exactly from LOAD through DONE.
